// File: rtl/vga_sync_timing.sv
// rtl/vga_sync_timing.sv - VGA raster timing: pixel enable, x/y counters, sync pins, blanking
// Counters advance once per pixel; hsync/vsync are registered from next-state so they line up with x/y.
module vga_sync_timing #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             h_end, v_end;

  assign p_tick = (div_q == DIV_LAST);
  assign h_end  = (h_q == H_LAST);
  assign v_end  = (v_q == V_LAST);

  always_comb begin
    div_d   = p_tick ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (p_tick) begin
      h_d = h_end ? '0 : h_q + 10'd1;
      if (h_end) begin
        v_d = v_end ? '0 : v_q + 10'd1;
      end
      // Sync derives from the value the counters are about to take, giving zero skew against x/y.
      hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign x          = h_q;
  assign y          = v_q;
  assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_tick = p_tick && h_end && v_end;

endmodule

// File: doc/vga_sync_timing.md
# vga_sync_timing

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz board clock. It produces the pixel coordinates (x, y) and the video_on blanking flag that feed the pixel_generation stage directly. It also produces the hsync/vsync pins, a pixel-rate enable (p_tick) and a once-per-frame pulse (frame_tick) for downstream game/animation logic.

## Interface
- CLK_DIV, 4: clk_100MHz cycles per pixel; 25 MHz pixel rate.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- clk_100MHz  in  1  system clock; the single clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high while (x, y) is inside the visible area.
- p_tick  out  1  one-clk-wide pixel enable, once every CLK_DIV clocks.
- frame_tick  out  1  one-clk-wide pulse on the last pixel of each frame.
- x  out  10  current horizontal count, 0..H_TOTAL-1.
- y  out  10  current vertical count, 0..V_TOTAL-1.

## Operation
- Totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
  - Both totals must be ≤1024; the 10-bit counters are unsigned.
- Divider:
  - 2-bit counter (width ceil(log2(CLK_DIV))) counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div == CLK_DIV-1), taken combinationally from the register.
- Horizontal counter h (drives x):
  - Advances only on a clock edge with p_tick=1.
  - At H_TOTAL-1 it wraps to 0; otherwise it increments.
- Vertical counter v (drives y):
  - Advances only on a p_tick edge where h == H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0; otherwise it increments.
  - Simultaneous h and v wrap (h=799, v=524) goes to (0,0) in one edge.
- hsync register:
  - Loaded on the same edges as h, from the next value of h.
  - Low iff the next h is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - This keeps hsync aligned with x with no skew.
- vsync register:
  - Loaded from the next value of v.
  - Low iff the next v is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- video_on = (h < H_DISPLAY) && (v < V_DISPLAY), combinational from the counter registers.
- frame_tick = p_tick && (h == H_TOTAL-1) && (v == V_TOTAL-1).
- Reset (async assert, any point mid-frame): div=0, h=0, v=0, hsync=1, vsync=1.
  - Consequence: x=0, y=0, video_on=1, p_tick=0, frame_tick=0 while reset_n is low.
- Release: counting resumes on the first clk edge after reset_n rises. No partial-frame recovery: the raster restarts at (0,0).

## Timing
- p_tick period is CLK_DIV clocks, one clock high.
- The first p_tick after reset release falls in clk cycle 4 (div 0→3).
- x/y/hsync/vsync change only on a p_tick edge, so each value is held for exactly CLK_DIV clocks.
- Latency from counter state to the sync pins is 0 pixels: sync is registered from next-state.
- Line = 800 pixels = 3200 clocks.
- Frame = 525 lines = 1,680,000 clocks (59.52 Hz at 100 MHz).
- hsync low for 96 pixels (384 clocks) per line.
- vsync low for 2 lines (6400 clocks) per frame.
- video_on falls on the edge where x goes 639→640 and rises on the edge where x goes 799→0, provided y<480.
- Downstream pixel_generation samples x/y/video_on combinationally. Consumers registering rgb must use p_tick as their enable.

## Test plan
- Reset: hold reset_n=0 for 10 clks, then assert it asynchronously between edges.
  - Outputs settle immediately to x=0, y=0, hsync=1, vsync=1, video_on=1, p_tick=0, frame_tick=0.
- Pixel enable: release reset and count clocks.
  - p_tick is high exactly every 4th clk.
  - x increments 0→1 on the first p_tick edge.
- Horizontal timing over one line:
  - hsync falls when x=656 and rises when x=752.
  - video_on=0 for x 640..799.
  - x wraps 799→0 as y goes 0→1.
- Vertical timing over a full frame:
  - vsync is low exactly while y=490..491.
  - video_on=0 for y≥480.
  - frame_tick pulses once, for 1 clk, at x=799/y=524.
  - The next frame_tick comes 1,680,000 clks later.
- Boundary at (799,524):
  - The next p_tick edge gives x=0, y=0, hsync=1, vsync=1, video_on=1 together.
- Mid-frame reset at x=700, y=491 (hsync and vsync both low):
  - Pulling reset_n low gives x=0, y=0, hsync=1, vsync=1 without waiting for a clk edge.
  - After release, the timing matches a fresh power-up exactly.
